axis_stream_tap: RTL and testbench
==================================

AXIS_STREAM_TAP -- requirements
Module: axis_stream_tap

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: upstream tdata width.
REQ-002 The block SHALL have parameter FIELD_LSB, default 16: LSB of the extracted field within s00_axis_tdata.
REQ-003 The block SHALL have parameter FIELD_WIDTH, default 16: extracted field width; multiple of 8; FIELD_LSB+FIELD_WIDTH <= DATA_WIDTH.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16: tap buffer entries; power of two, >= 2.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- s00_axis_aclk, in, 1: sole clock.
- s00_axis_aresetn, in, 1: reset, asynchronous, active-low.
- s00_axis_tvalid / s00_axis_tready / s00_axis_tlast, in, 1 each: observed upstream handshake. All inputs; never driven.
- s00_axis_tdata, in, DATA_WIDTH: observed data.
- enable, in, 1: capture enable.
- decim, in, 8: keep one of every decim beats; 0 is treated as 1.
- clear_stats, in, 1: single-cycle pulse clearing statistics.
- m01_axis_tvalid, out, 1: tap output valid.
- m01_axis_tready, in, 1: tap output ready; honoured.
- m01_axis_tdata, out, FIELD_WIDTH: extracted field.
- m01_axis_tlast, out, 1: copy of captured tlast.
- m01_axis_tstrb, out, FIELD_WIDTH/8: strobe.
- beat_count, out, CNT_WIDTH: observed upstream handshakes.
- drop_count, out, CNT_WIDTH: captures lost to a full FIFO.
- overflow, out, 1: sticky flag, set on any drop.

Function
REQ-007 An upstream beat SHALL be observed only on s00_axis_tvalid && s00_axis_tready; valid without ready SHALL be ignored.
REQ-008 beat_count SHALL increment on every observed beat regardless of enable, saturating at all-ones.
REQ-009 A decimation counter SHALL advance on observed beats while enable=1 and SHALL qualify a capture when it equals 0; it SHALL wrap to 0 when it reaches max(decim,1)-1.
REQ-010 A decim value lowered below the current count SHALL take effect immediately by wrapping on the next observed beat.
REQ-011 An observed beat with tlast=1 while enable=1 SHALL always be captured, and SHALL force the decimation counter to 0 for the following beat.
REQ-012 Each capture SHALL push the entry {tlast, tdata[FIELD_LSB +: FIELD_WIDTH]} into the FIFO.
REQ-013 A capture while the FIFO is full, with no pop in the same cycle, SHALL be discarded; drop_count SHALL increment (saturating) and overflow SHALL set.
REQ-014 A capture while the FIFO is full with a simultaneous pop SHALL be accepted.
REQ-015 m01_axis_tvalid SHALL equal FIFO not-empty, and m01_axis_tdata/tlast SHALL present the head entry (show-ahead).
REQ-016 A pop SHALL occur on m01_axis_tvalid && m01_axis_tready.
REQ-017 Capture-to-output latency SHALL be 1 cycle: a beat captured at edge N SHALL be visible on m01 after edge N.
REQ-018 m01_axis_tdata and m01_axis_tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-019 m01_axis_tstrb SHALL be constant all-ones.
REQ-020 Deasserting enable SHALL stop captures but SHALL NOT flush the FIFO; buffered entries SHALL continue to drain.
REQ-021 clear_stats SHALL zero beat_count, drop_count and overflow on the next edge, and SHALL take priority over a same-cycle increment.
REQ-022 clear_stats SHALL NOT touch the FIFO or the decimation counter.

Reset
REQ-023 Assertion of s00_axis_aresetn=0 SHALL immediately empty the FIFO and zero the decimation counter, beat_count, drop_count and overflow, forcing m01_axis_tvalid=0 and m01_axis_tlast=0; m01_axis_tdata SHALL be 0.
REQ-024 Reset mid-packet SHALL discard partial state; the first observed beat after release SHALL be treated as decimation phase 0.

Structure
REQ-025 Package axis_tap_pkg SHALL hold the FIFO entry struct typedef (last, field), parameterised via a localparam FIELD width default, and the saturating-increment function.
REQ-026 The FIFO SHALL be a separate sub-module, tap_sync_fifo, with a show-ahead read, a full/empty pair and simultaneous push/pop support; all control, decimation and statistics logic SHALL be in axis_stream_tap.

Verification
REQ-027 With decim=1, enable=1 and ready held 1, driving 4 beats tdata=0xAAAA0001..0xAAAA0004, tlast on the 4th, SHALL produce m01 tdata 0xAAAA x4, tlast on the 4th only, each 1 cycle later, and beat_count=4.
REQ-028 With decim=3 and a 7-beat packet (field values 0..6, tlast on beat 6), the output SHALL be fields 0, 3, 6 with tlast on 6; a following packet SHALL again start with its beat 0.
REQ-029 Upstream tvalid=1 with tready=0 for 5 cycles SHALL yield no capture and beat_count unchanged.
REQ-030 With FIFO_DEPTH=16, m01 ready=0 and 20 captures, the FIFO SHALL hold the first 16, drop_count SHALL be 4 and overflow=1; on releasing ready, exactly the 16 SHALL drain in order.
REQ-031 With the FIFO full, a simultaneous pop and capture SHALL be accepted with drop_count unchanged.
REQ-032 Reset asserted mid-drain with 5 entries buffered SHALL force m01_axis_tvalid=0 and all counters to 0 asynchronously; clear_stats asserted on a capture cycle SHALL leave beat_count=0.

Source files
------------

// File: rtl/axis_tap_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_tap_pkg : shared entry type and saturating-increment helper      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package axis_tap_pkg;

    localparam int TAP_FIELD_W = 16;
    localparam int SAT_W       = 32;

    typedef struct packed {
        logic                   last;
        logic [TAP_FIELD_W-1:0] field;
    } tap_entry_t;

    // Counters up to SAT_W bits wide share this helper; callers zero-extend in and truncate out.
    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] max_value
    );
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage : axis_tap_pkg
`default_nettype wire

// File: rtl/axis_stream_tap_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tap_sync_fifo : show-ahead synchronous FIFO with simultaneous push/pop|
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tap_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop_i & ~empty_o;
    // When full, a pop frees the slot being written in the same cycle.
    assign w_do_push = push_i & (~full_o | w_do_pop);

    assign wr_ptr_d  = w_do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d  = w_do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    assign dout_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule : tap_sync_fifo
`default_nettype wire

// File: rtl/axis_stream_tap.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | axis_stream_tap : passive AXI-Stream monitor with decimated field tap |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module axis_stream_tap
    import axis_tap_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FIELD_LSB   = 16,
    parameter int FIELD_WIDTH = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     s00_axis_aclk,
    input  logic                     s00_axis_aresetn,
    input  logic                     s00_axis_tvalid,
    input  logic                     s00_axis_tready,
    input  logic                     s00_axis_tlast,
    input  logic [DATA_WIDTH-1:0]    s00_axis_tdata,
    input  logic                     enable,
    input  logic [7:0]               decim,
    input  logic                     clear_stats,
    output logic                     m01_axis_tvalid,
    input  logic                     m01_axis_tready,
    output logic [FIELD_WIDTH-1:0]   m01_axis_tdata,
    output logic                     m01_axis_tlast,
    output logic [FIELD_WIDTH/8-1:0] m01_axis_tstrb,
    output logic [CNT_WIDTH-1:0]     beat_count,
    output logic [CNT_WIDTH-1:0]     drop_count,
    output logic                     overflow
);

    localparam int              ENTRY_W = FIELD_WIDTH + 1;
    localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_WIDTH{1'b1}});

    logic                 w_beat;
    logic [7:0]           w_decim_eff;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_fifo_din;
    logic [ENTRY_W-1:0]   w_fifo_dout;
    logic                 unused_tdata_bits;

    logic [7:0]           dec_cnt_q, dec_cnt_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 ovf_q, ovf_d;

    assign w_beat      = s00_axis_tvalid & s00_axis_tready;
    assign w_decim_eff = (decim == 8'd0) ? 8'd1 : decim;
    assign w_capture   = w_beat & enable & ((dec_cnt_q == 8'd0) | s00_axis_tlast);
    assign w_pop       = m01_axis_tvalid & m01_axis_tready;
    assign w_drop      = w_capture & w_full & ~w_pop;
    assign w_fifo_din  = {s00_axis_tlast, s00_axis_tdata[FIELD_LSB +: FIELD_WIDTH]};
    assign unused_tdata_bits = ^s00_axis_tdata;

    // ">=" rather than "==" so a decim lowered below the running count wraps at once.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (w_beat && enable) begin
            if (s00_axis_tlast || (dec_cnt_q >= w_decim_eff - 8'd1)) begin
                dec_cnt_d = 8'd0;
            end else begin
                dec_cnt_d = dec_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        beat_d = beat_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clear_stats) begin
            beat_d = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (w_beat) begin
                beat_d = CNT_WIDTH'(sat_inc(SAT_W'(beat_q), CNT_MAX));
            end
            if (w_drop) begin
                drop_d = CNT_WIDTH'(sat_inc(SAT_W'(drop_q), CNT_MAX));
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            dec_cnt_q <= 8'd0;
            beat_q    <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            beat_q    <= beat_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    tap_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (s00_axis_aclk),
        .rst_ni  (s00_axis_aresetn),
        .push_i  (w_capture),
        .din_i   (w_fifo_din),
        .pop_i   (w_pop),
        .dout_o  (w_fifo_dout),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign m01_axis_tvalid = ~w_empty;
    assign m01_axis_tlast  = w_fifo_dout[ENTRY_W-1];
    assign m01_axis_tdata  = w_fifo_dout[FIELD_WIDTH-1:0];
    assign m01_axis_tstrb  = '1;
    assign beat_count      = beat_q;
    assign drop_count      = drop_q;
    assign overflow        = ovf_q;

endmodule : axis_stream_tap
`default_nettype wire

// File: tb/tb_axis_stream_tap.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_axis_stream_tap : directed scoreboard bench for axis_stream_tap    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_axis_stream_tap;
    import axis_tap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        enable, clear_stats;
    logic [7:0]  decim;
    logic        m_tvalid, m_tready, m_tlast;
    logic [15:0] m_tdata;
    logic [1:0]  m_tstrb;
    logic [15:0] beat_count, drop_count;
    logic        overflow;

    tap_entry_t  sb [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axis_stream_tap #(
        .DATA_WIDTH  (32),
        .FIELD_LSB   (16),
        .FIELD_WIDTH (16),
        .FIFO_DEPTH  (16),
        .CNT_WIDTH   (16)
    ) dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis_tvalid  (s_tvalid),
        .s00_axis_tready  (s_tready),
        .s00_axis_tlast   (s_tlast),
        .s00_axis_tdata   (s_tdata),
        .enable           (enable),
        .decim            (decim),
        .clear_stats      (clear_stats),
        .m01_axis_tvalid  (m_tvalid),
        .m01_axis_tready  (m_tready),
        .m01_axis_tdata   (m_tdata),
        .m01_axis_tlast   (m_tlast),
        .m01_axis_tstrb   (m_tstrb),
        .beat_count       (beat_count),
        .drop_count       (drop_count),
        .overflow         (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare any pop due at the coming edge, then return 1 ns after it.
    task automatic cycle();
        tap_entry_t e;
        @(negedge clk);
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(m_tvalid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(m_tdata), 32'(e.field));
                chk("out_last", 32'(m_tlast), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic expect_cap);
        s_tvalid = 1'b1;
        s_tready = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        if (expect_cap) sb.push_back('{last: last, field: d[31:16]});
        cycle();
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        m_tready = 1'b1;
        while (sb.size() != 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_tvalid", 32'(m_tvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        s_tvalid    = 1'b0;
        s_tready    = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = 32'd0;
        enable      = 1'b0;
        decim       = 8'd1;
        clear_stats = 1'b0;
        m_tready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_beat", 32'(beat_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("tstrb", 32'(m_tstrb), 32'h3);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-rate packet, ready held high
        enable   = 1'b1;
        decim    = 8'd1;
        m_tready = 1'b1;
        beat(32'hAAAA0001, 1'b0, 1'b1);
        chk("lat_valid", 32'(m_tvalid), 32'd1);
        chk("lat_data", 32'(m_tdata), 32'hAAAA);
        beat(32'hAAAA0002, 1'b0, 1'b1);
        beat(32'hAAAA0003, 1'b0, 1'b1);
        beat(32'hAAAA0004, 1'b1, 1'b1);
        drain(10);
        chk("beat_count_4", 32'(beat_count), 32'd4);

        // Decimate by 3; tlast re-phases the next packet
        decim = 8'd3;
        for (int i = 0; i < 7; i++) beat({16'(i), 16'h0}, i == 6, (i % 3) == 0);
        for (int i = 0; i < 3; i++) beat({16'(10 + i), 16'h0}, 1'b0, i == 0);
        drain(10);
        chk("beat_count_14", 32'(beat_count), 32'd14);

        // Valid without ready is not a beat
        s_tvalid = 1'b1;
        s_tready = 1'b0;
        s_tdata  = 32'h7777_0000;
        repeat (5) cycle();
        s_tvalid = 1'b0;
        chk("noready_beat", 32'(beat_count), 32'd14);
        chk("noready_tvalid", 32'(m_tvalid), 32'd0);

        // decim lowered mid-count, decim=0 as 1, enable low
        decim = 8'd4;
        beat(32'h0020_0000, 1'b0, 1'b1);
        beat(32'h0021_0000, 1'b0, 1'b0);
        beat(32'h0022_0000, 1'b0, 1'b0);
        decim = 8'd2;
        beat(32'h0023_0000, 1'b0, 1'b0);
        beat(32'h0024_0000, 1'b0, 1'b1);
        decim = 8'd0;
        beat(32'h0025_0000, 1'b0, 1'b0);
        beat(32'h0026_0000, 1'b0, 1'b1);
        beat(32'h0027_0000, 1'b0, 1'b1);
        enable = 1'b0;
        beat(32'h0028_0000, 1'b0, 1'b0);
        beat(32'h0029_0000, 1'b1, 1'b0);
        enable = 1'b1;
        drain(10);
        chk("beat_count_24", 32'(beat_count), 32'd24);

        // Overflow: 20 captures into 16 entries, then full with simultaneous pop
        m_tready = 1'b0;
        decim    = 8'd1;
        for (int i = 0; i < 20; i++) beat({16'(16'h0100 + i), 16'h0}, 1'b0, i < 16);
        chk("ovf_drop", 32'(drop_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_tvalid", 32'(m_tvalid), 32'd1);
        chk("ovf_head_stable", 32'(m_tdata), 32'h0100);
        m_tready = 1'b1;
        beat(32'h01FF_0000, 1'b1, 1'b1);
        chk("fullpop_drop", 32'(drop_count), 32'd4);
        drain(40);
        chk("beat_count_45", 32'(beat_count), 32'd45);

        // clear_stats on a capture cycle keeps the FIFO
        m_tready    = 1'b0;
        clear_stats = 1'b1;
        beat(32'h0300_0000, 1'b0, 1'b1);
        clear_stats = 1'b0;
        chk("clr_beat", 32'(beat_count), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_fifo_kept", 32'(m_tdata), 32'h0300);
        beat(32'h0301_0000, 1'b0, 1'b1);
        chk("clr_beat_1", 32'(beat_count), 32'd1);
        drain(10);

        // Async reset mid-drain with 5 entries left and decim phase non-zero
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) beat({16'(16'h0400 + i), 16'h0}, 1'b0, 1'b1);
        decim = 8'd3;
        beat(32'h0407_0000, 1'b0, 1'b1);
        m_tready = 1'b1;
        repeat (3) cycle();
        chk("pre_rst_left", 32'(sb.size()), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(m_tvalid), 32'd0);
        chk("arst_tdata", 32'(m_tdata), 32'd0);
        chk("arst_tlast", 32'(m_tlast), 32'd0);
        chk("arst_beat", 32'(beat_count), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        beat(32'h0500_0000, 1'b0, 1'b1);
        beat(32'h0501_0000, 1'b0, 1'b0);
        drain(10);
        chk("post_rst_beat", 32'(beat_count), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_axis_stream_tap
`default_nettype wire
